mux_rr_stream: RTL

Parametrised N-channel, W-bit stream multiplexer with round-robin arbitration, valid/ready handshakes on every input and on the output, and one registered output stage. It is the clocked successor of the 4:1 selector mux: the select input is removed; the block picks which requester is forwarded, and it holds data until the consumer accepts it. It sits between several producers and a single shared consumer, such as a shared ALU port or bus.

---
 rtl/mux_rr_stream.sv | 89 ++++++++
 1 files changed

// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream mux with a registered output stage and round-robin arbitration.
// Define MUX_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module mux_rr_stream #(
    parameter int W = 4,
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_sel
);

    localparam int unsigned NU = N;

    logic [W-1:0]  data_q;
    logic          valid_q;
    logic [SW-1:0] sel_q;
    logic [SW-1:0] last_q;

    logic          found;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic          can_load;
    logic          load;
    int unsigned   idx;

    always_comb begin
        found      = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
`ifdef MUX_PRIO_EN
        for (int unsigned i = 0; i < NU; i++) begin
            if (in_valid[i] && !found) begin
                found      = 1'b1;
                grant_idx  = SW'(i);
                grant_data = in_data[i*W +: W];
            end
        end
`else
        // Search starts just after the last winner and wraps modulo N.
        for (int unsigned k = 1; k <= NU; k++) begin
            idx = (32'(last_q) + k) % NU;
            if (in_valid[idx] && !found) begin
                found      = 1'b1;
                grant_idx  = SW'(idx);
                grant_data = in_data[idx*W +: W];
            end
        end
`endif
    end

    assign can_load = !valid_q || out_ready;
    assign load     = can_load && found;

    always_comb begin
        in_ready = '0;
        if (load && !rst) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            last_q  <= SW'(N - 1);
        end else if (load) begin
            data_q  <= grant_data;
            valid_q <= 1'b1;
            sel_q   <= grant_idx;
            last_q  <= grant_idx;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;

endmodule
